// File: rtl/sr_sched_pkg.sv
// ============================================================================
// Module   : sr_sched_pkg
// Purpose  : Shared op encodings, FSM state type and default sizing for the
//            SR flag scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_sched_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_N_FLAG = 8;
  localparam int DEF_IDXW   = 3;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_APPLY = 2'd2
  } sched_state_t;

  function automatic logic op_opposes(input logic [1:0] a, input logic [1:0] b);
    return ((a == OP_SET) && (b == OP_RST)) || ((a == OP_RST) && (b == OP_SET));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_flop_cell.sv
// ============================================================================
// Module   : sr_flop_cell
// Purpose  : Clocked SR storage cell; set/reset act at the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_flop_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar
);

  logic r_q;

  // s=r=1 is never driven by the scheduler; holding is the safe fallback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (s && !r) begin
      r_q <= 1'b1;
    end else if (r && !s) begin
      r_q <= 1'b0;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

`default_nettype wire

// File: rtl/sr_flag_scheduler.sv
// ============================================================================
// Module   : sr_flag_scheduler
// Purpose  : Round-robin arbiter applying set/reset commands to a bank of SR
//            flag cells. Optional SR_SCHED_CONFLICT_EN flags opposing ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_flag_scheduler
  import sr_sched_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int N_FLAG = DEF_N_FLAG,
  parameter int IDXW   = DEF_IDXW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [IDXW*N_REQ-1:0]  req_idx,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_FLAG-1:0]      q,
  output logic [N_FLAG-1:0]      qbar,
  output logic                   busy,
  output logic                   err
);

  localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t r_state;
  sched_state_t w_state_next;

  logic [N_REQ-1:0]      r_req_snap;
  logic [2*N_REQ-1:0]    r_op_snap;
  logic [IDXW*N_REQ-1:0] r_idx_snap;

  logic [PTRW-1:0] r_ptr;
  logic [PTRW-1:0] r_winner;
  logic [1:0]      r_op;
  logic [IDXW-1:0] r_idx;

  logic [PTRW-1:0] w_winner;
  logic [PTRW-1:0] w_ptr_next;
  logic [1:0]      w_win_op;
  logic [IDXW-1:0] w_win_idx;
  logic            w_idx_ok;

  logic [N_FLAG-1:0] w_s;
  logic [N_FLAG-1:0] w_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (|req) w_state_next = ST_ARB;
      ST_ARB:   w_state_next = ST_APPLY;
      ST_APPLY: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Round-robin search over the request snapshot, beginning at r_ptr
  always_comb begin
    logic            found;
    logic [PTRW:0]   sum;
    w_winner = r_ptr;
    found    = 1'b0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, r_ptr} + (PTRW+1)'(k);
      if (sum >= (PTRW+1)'(N_REQ)) sum = sum - (PTRW+1)'(N_REQ);
      if (!found && r_req_snap[sum[PTRW-1:0]]) begin
        found    = 1'b1;
        w_winner = sum[PTRW-1:0];
      end
    end
  end

  always_comb begin
    logic [PTRW:0] nxt;
    nxt = {1'b0, w_winner} + (PTRW+1)'(1);
    if (nxt >= (PTRW+1)'(N_REQ)) nxt = nxt - (PTRW+1)'(N_REQ);
    w_ptr_next = nxt[PTRW-1:0];
  end

  always_comb begin
    w_win_op  = OP_HOLD;
    w_win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_winner == PTRW'(k)) begin
        w_win_op  = r_op_snap[2*k +: 2];
        w_win_idx = r_idx_snap[IDXW*k +: IDXW];
      end
    end
  end

`ifdef SR_SCHED_CONFLICT_EN
  logic r_conflict;
  logic w_conflict;

  always_comb begin
    w_conflict = 1'b0;
    for (int a = 0; a < N_REQ; a++) begin
      for (int b = a + 1; b < N_REQ; b++) begin
        if (r_req_snap[a] && r_req_snap[b] &&
            (r_idx_snap[IDXW*a +: IDXW] == r_idx_snap[IDXW*b +: IDXW]) &&
            op_opposes(r_op_snap[2*a +: 2], r_op_snap[2*b +: 2])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict <= 1'b0;
    end else if (r_state == ST_ARB) begin
      r_conflict <= w_conflict;
    end
  end
`endif

  // Requests are frozen at IDLE exit so late arrivals cannot steer ARB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_snap <= '0;
      r_op_snap  <= '0;
      r_idx_snap <= '0;
      r_ptr      <= '0;
      r_winner   <= '0;
      r_op       <= OP_HOLD;
      r_idx      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_req_snap <= req;
            r_op_snap  <= req_op;
            r_idx_snap <= req_idx;
          end
        end
        ST_ARB: begin
          r_winner <= w_winner;
          r_op     <= w_win_op;
          r_idx    <= w_win_idx;
          r_ptr    <= w_ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign w_idx_ok = ({1'b0, r_idx} < (IDXW+1)'(N_FLAG));

  always_comb begin
    gnt  = '0;
    busy = (r_state != ST_IDLE);
    err  = 1'b0;
    w_s  = '0;
    w_r  = '0;
    if (r_state == ST_APPLY) begin
      gnt[r_winner] = 1'b1;
`ifdef SR_SCHED_CONFLICT_EN
      err = (r_op == OP_ILL) || !w_idx_ok || r_conflict;
`else
      err = (r_op == OP_ILL) || !w_idx_ok;
`endif
      for (int k = 0; k < N_FLAG; k++) begin
        if (w_idx_ok && (r_idx == IDXW'(k))) begin
          case (r_op)
            OP_SET:  w_s[k] = 1'b1;
            OP_RST:  w_r[k] = 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_FLAG; g++) begin : g_cell
      sr_flop_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .s    (w_s[g]),
        .r    (w_r[g]),
        .q    (q[g]),
        .qbar (qbar[g])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sr_flag_scheduler.sv
// ============================================================================
// Module   : tb_sr_flag_scheduler
// Purpose  : Directed scenarios with a grant scoreboard and per-cycle
//            invariant monitor for sr_flag_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_flag_scheduler;
  import sr_sched_pkg::*;

`ifdef SR_SCHED_CONFLICT_EN
  localparam logic CONF = 1'b1;
`else
  localparam logic CONF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_op = '0;
  logic [11:0] req_idx = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        busy;
  logic        err;

  sr_flag_scheduler #(.N_REQ(4), .N_FLAG(8), .IDXW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_op  (req_op),
    .req_idx (req_idx),
    .gnt     (gnt),
    .q       (q),
    .qbar    (qbar),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [7:0] qv;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_q = '0;
  logic       qpend = 1'b0;
  logic [7:0] qexp = '0;

  always @(negedge clk) begin
    if (rst) begin
      qpend = 1'b0;
    end else begin
      total++;
      if (!$onehot0(gnt)) begin bad++; $display("FAIL gnt_onehot got=%b want=zero-or-one-hot", gnt); end
      total++;
      if (qbar !== ~q) begin bad++; $display("FAIL qbar got=%h want=%h", qbar, ~q); end
      total++;
      if ((dut.w_s & dut.w_r) !== 8'h00) begin bad++; $display("FAIL s_and_r got=%h want=00", dut.w_s & dut.w_r); end
      if (gnt !== 4'b0000) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL unexpected_gnt got=%b want=none", gnt);
        end else begin
          cur = sb.pop_front();
          if (gnt !== 4'(1 << cur.who)) begin bad++; $display("FAIL sb_gnt got=%b want=%b", gnt, 4'(1 << cur.who)); end
          total++;
          if (err !== cur.e) begin bad++; $display("FAIL sb_err got=%b want=%b", err, cur.e); end
          qpend = 1'b1;
          qexp  = cur.qv;
        end
      end else if (qpend) begin
        total++;
        if (q !== qexp) begin bad++; $display("FAIL sb_q got=%h want=%h", q, qexp); end
        qpend = 1'b0;
      end
    end
  end

  function automatic logic [7:0] model_q(input logic [7:0] c, input logic [1:0] op, input logic [2:0] idx);
    logic [7:0] m;
    m = 8'h01 << idx;
    if (op == OP_SET) return c | m;
    if (op == OP_RST) return c & ~m;
    return c;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick;
    tick;
    rst = 1'b0;
    m_q = '0;
  endtask

  task automatic set_cmd(input int who, input logic [1:0] op, input logic [2:0] idx);
    req_op[2*who +: 2]  = op;
    req_idx[3*who +: 3] = idx;
    req[who]            = 1'b1;
  endtask

  task automatic push_exp(input int who, input logic [1:0] op, input logic [2:0] idx, input logic e);
    m_q = model_q(m_q, op, idx);
    sb.push_back('{who, m_q, e});
  endtask

  task automatic do_req(input int who, input logic [1:0] op, input logic [2:0] idx, output int errs);
    logic got;
    push_exp(who, op, idx, op == OP_ILL);
    set_cmd(who, op, idx);
    errs = 0;
    got  = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick;
      if (err) errs++;
      if (gnt[who]) got = 1'b1;
    end
    if (!got) begin total++; bad++; $display("FAIL req_timeout got=none want=gnt[%0d]", who); end
    tick;
    req[who] = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    total++; if (gnt !== 4'h0)   begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
    total++; if (q !== 8'h00)    begin bad++; $display("FAIL rst_q got=%h want=00", q); end
    total++; if (qbar !== 8'hFF) begin bad++; $display("FAIL rst_qbar got=%h want=ff", qbar); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b want=0", err); end
  endtask

  task automatic test_single_set;
    rst = 1'b0;
    m_q = '0;
    push_exp(0, OP_SET, 3'd3, 1'b0);
    set_cmd(0, OP_SET, 3'd3);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL set_pre_busy got=%b want=0", busy); end
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL set_arb_busy got=%b want=1", busy); end
    total++; if (gnt !== 4'h0)  begin bad++; $display("FAIL set_arb_gnt got=%b want=0000", gnt); end
    tick;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL set_apply_gnt got=%b want=0001", gnt); end
    total++; if (busy !== 1'b1)   begin bad++; $display("FAIL set_apply_busy got=%b want=1", busy); end
    total++; if (q !== 8'h00)     begin bad++; $display("FAIL set_apply_q got=%h want=00", q); end
    tick;
    req[0] = 1'b0;
    total++; if (q !== 8'h08)   begin bad++; $display("FAIL set_q got=%h want=08", q); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL set_idle_busy got=%b want=0", busy); end
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL set_stay_idle got=%b want=0", busy); end
  endtask

  task automatic test_round_robin;
    int ngr, last, drop, cyc;
    do_reset;
    for (int i = 0; i < 4; i++) push_exp(i, OP_SET, 3'(i), 1'b0);
    for (int i = 0; i < 4; i++) set_cmd(i, OP_SET, 3'(i));
    ngr = 0; last = -1; drop = -1; cyc = 0;
    while ((ngr < 4 || drop >= 0) && cyc < 40) begin
      tick;
      cyc++;
      if (drop >= 0) begin req[drop] = 1'b0; drop = -1; end
      if (gnt !== 4'h0) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) drop = i;
        if (last >= 0) begin
          total++;
          if (cyc - last !== 3) begin bad++; $display("FAIL rr_spacing got=%0d want=3", cyc - last); end
        end
        last = cyc;
        ngr++;
      end
    end
    total++; if (ngr !== 4)    begin bad++; $display("FAIL rr_count got=%0d want=4", ngr); end
    total++; if (q !== 8'h0F)  begin bad++; $display("FAIL rr_q got=%h want=0f", q); end
  endtask

  task automatic test_illegal_op;
    int errs;
    do_reset;
    do_req(2, OP_SET, 3'd5, errs);
    total++; if (q !== 8'h20) begin bad++; $display("FAIL ill_pre_q got=%h want=20", q); end
    do_req(2, OP_ILL, 3'd5, errs);
    total++; if (errs !== 1)  begin bad++; $display("FAIL ill_err_pulses got=%0d want=1", errs); end
    total++; if (q !== 8'h20) begin bad++; $display("FAIL ill_q got=%h want=20", q); end
    do_req(1, OP_HOLD, 3'd5, errs);
    total++; if (errs !== 0)  begin bad++; $display("FAIL hold_err got=%0d want=0", errs); end
    total++; if (q !== 8'h20) begin bad++; $display("FAIL hold_q got=%h want=20", q); end
    do_req(3, OP_RST, 3'd5, errs);
    total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_op_q got=%h want=00", q); end
  endtask

  task automatic test_conflict;
    int e1, e2;
    logic got;
    do_reset;
    push_exp(0, OP_SET, 3'd1, CONF);
    push_exp(1, OP_RST, 3'd1, 1'b0);
    set_cmd(0, OP_SET, 3'd1);
    set_cmd(1, OP_RST, 3'd1);
    e1 = 0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick;
      if (err) e1++;
      if (gnt[0]) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL conf_gnt0 got=none want=0001"); end
    tick;
    req[0] = 1'b0;
    total++; if (q[1] !== 1'b1) begin bad++; $display("FAIL conf_q1 got=%b want=1", q[1]); end
    e2 = 0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick;
      if (err) e2++;
      if (gnt[1]) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL conf_gnt1 got=none want=0010"); end
    tick;
    req[1] = 1'b0;
    tick;
    total++; if (e1 !== int'(CONF)) begin bad++; $display("FAIL conf_err got=%0d want=%0d", e1, CONF); end
    total++; if (e2 !== 0)           begin bad++; $display("FAIL conf_err2 got=%0d want=0", e2); end
    total++; if (q !== 8'h00)        begin bad++; $display("FAIL conf_q got=%h want=00", q); end
  endtask

  task automatic test_back_to_back;
    logic got;
    do_reset;
    push_exp(1, OP_SET, 3'd4, 1'b0);
    push_exp(0, OP_SET, 3'd2, 1'b0);
    set_cmd(1, OP_SET, 3'd4);
    tick;
    set_cmd(0, OP_SET, 3'd2);
    tick;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL b2b_late_gnt got=%b want=0010", gnt); end
    tick;
    req[1] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick;
      if (gnt[0]) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL b2b_gnt0 got=none want=0001"); end
    tick;
    req[0] = 1'b0;
    tick;
    total++; if (q !== 8'h14) begin bad++; $display("FAIL b2b_q got=%h want=14", q); end
  endtask

  task automatic test_reset_mid_apply;
    do_reset;
    set_cmd(3, OP_SET, 3'd7);
    tick;
    tick;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL mid_pre_gnt got=%b want=1000", gnt); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'h0)  begin bad++; $display("FAIL mid_gnt got=%b want=0000", gnt); end
    total++; if (q !== 8'h00)   begin bad++; $display("FAIL mid_q got=%h want=00", q); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0)  begin bad++; $display("FAIL mid_err got=%b want=0", err); end
    req = '0;
    tick;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    total++; if (q[7] !== 1'b0) begin bad++; $display("FAIL mid_q7 got=%b want=0", q[7]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b want=0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single_set;
    test_round_robin;
    test_illegal_op;
    test_conflict;
    test_back_to_back;
    test_reset_mid_apply;
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sr_flag_scheduler.md
SR_FLAG_SCHEDULER -- requirements
Module: sr_flag_scheduler

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters; N_FLAG, default 8, number of SR flag cells; IDXW, default 3, flag index width, equal to clog2(N_FLAG).
REQ-002 Ports SHALL be as follows, one per line, clock and reset first:
  clk      in   1            single system clock, rising edge
  rst      in   1            asynchronous, active-high reset
  req      in   N_REQ        per-requester request, level, held until granted
  req_op   in   2*N_REQ      per-requester op: 01 set, 10 reset, 00 hold, 11 illegal
  req_idx  in   IDXW*N_REQ   per-requester target flag index
  gnt      out  N_REQ        one-hot grant pulse, one cycle
  q        out  N_FLAG       flag states
  qbar     out  N_FLAG       complement of q
  busy     out  1            high whenever the FSM is not in IDLE
  err      out  1            one-cycle error pulse

Function
REQ-003 FSM SHALL have exactly three states, IDLE, ARB and APPLY, with IDLE -> ARB when any req bit is set, ARB -> APPLY unconditionally, and APPLY -> IDLE unconditionally.
REQ-004 In ARB the block SHALL pick the winner round-robin, starting the search at pointer ptr, and register its op and idx.
REQ-005 ptr SHALL update to (winner+1) mod N_REQ on the ARB->APPLY edge, and SHALL hold otherwise.
REQ-006 In APPLY, gnt[winner] SHALL be high for exactly one cycle, and every other gnt bit SHALL be 0.
REQ-007 In APPLY, the cell at the registered idx SHALL receive s=1,r=0 for op 01, s=0,r=1 for op 10, and s=0,r=0 for op 00 or 11.
REQ-008 No cell SHALL ever receive s=1 and r=1 at the same time.
REQ-009 q SHALL change only at the edge that ends APPLY: the request is sampled at edge e0, q updates at edge e2, and the block is ready for a new arbitration at edge e3.
REQ-010 Op 11 SHALL still be granted, SHALL leave q unchanged, and SHALL pulse err during APPLY.
REQ-011 Requests arriving or dropping during ARB or APPLY SHALL be ignored until the next IDLE; the registered winner command is not altered.
REQ-012 A requester SHALL deassert req in the cycle after its gnt; a req still high in IDLE is treated as a new request.
REQ-013 An idx >= N_FLAG SHALL be treated as illegal: the request is granted, no cell changes, and err pulses.
REQ-014 qbar SHALL always equal ~q.

Reset
REQ-015 Asserting rst at any time, including mid-ARB or mid-APPLY, SHALL immediately force state=IDLE, ptr=0, q=0, qbar=all-ones, gnt=0, busy=0 and err=0.
REQ-016 A command in flight when rst asserts SHALL be discarded, with no grant and no flag change.
REQ-017 The first arbitration after rst deasserts SHALL occur no earlier than the first rising edge after deassertion.

Configuration
REQ-018 When SR_SCHED_CONFLICT_EN is defined, ARB SHALL detect two or more active requesters targeting the same idx with opposite ops (01 vs 10); err then pulses during APPLY, and the winner is still applied normally.
REQ-019 When SR_SCHED_CONFLICT_EN is undefined, no conflict detection logic SHALL be built, and err pulses only per REQ-010 and REQ-013.

Structure
REQ-020 A package sr_sched_pkg SHALL hold the op encodings (OP_HOLD, OP_SET, OP_RST, OP_ILL), the FSM state typedef and the default parameter constants.
REQ-021 The single sub-module SHALL be sr_flop_cell, a clocked SR cell with inputs s, r, clk and rst and outputs q and qbar, instantiated N_FLAG times.
REQ-022 All arbitration and decoding logic SHALL reside in sr_flag_scheduler.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  - Single set: req[0]=1, op=01, idx=3 from reset -> gnt=0001 at cycle 2, q=0x08 after edge e2, busy high for 2 cycles.
  - Round-robin: req=1111, all op=01, idx=0..3, held until granted -> grant order 0,1,2,3, q=0x0F, each grant 3 cycles apart.
  - Illegal op: req[2]=1, op=11, idx=5, q=0x20 -> gnt=0100, err pulses once, q remains 0x20.
  - Conflict (macro defined): req[0] op=01 idx=1 and req[1] op=10 idx=1, ptr=0 -> gnt=0001, q[1]=1, err pulses; with macro undefined, err stays 0.
  - Reset mid-APPLY: rst asserted during APPLY of a set to idx 7 -> q=0x00 and gnt=0 immediately, state IDLE, idx 7 is never set.
  - Invariant check, every cycle: no cell ever sees s=r=1, gnt is zero- or one-hot, and qbar == ~q.
